// File: rtl/hyperbus_wb_bridge_if.sv
// rtl/hyperbus_wb_bridge_if.sv - Wishbone slave and hyperbus request port bundle
interface hyperbus_wb_bridge_if;
  // Wishbone side
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  // Controller request side
  logic [31:0] hb_adr_o;
  logic [15:0] hb_dat_o;
  logic [15:0] hb_dat_i;
  logic        hb_wrq_o;
  logic        hb_rrq_o;
  logic        hb_reg_space_o;
  logic        hb_busy_i;
  logic        hb_error_i;

  // Bridge view
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output hb_adr_o, hb_dat_o, hb_wrq_o, hb_rrq_o, hb_reg_space_o,
    input  hb_dat_i, hb_busy_i, hb_error_i
  );

  // Wishbone master plus controller view
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  hb_adr_o, hb_dat_o, hb_wrq_o, hb_rrq_o, hb_reg_space_o,
    output hb_dat_i, hb_busy_i, hb_error_i
  );
endinterface

// File: rtl/hyperbus_wb_bridge.sv
// rtl/hyperbus_wb_bridge.sv - Wishbone 32-bit slave splitting accesses into 16-bit hyperbus requests
module hyperbus_wb_bridge #(
  parameter int          START_TIMEOUT = 64,
  parameter logic [15:0] READ_SKIP_VAL = 16'h0000
) (
  input logic                 clk,
  input logic                 rst,
  hyperbus_wb_bridge_if.slave bus
);

  localparam int TW = $clog2(START_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT,
    S_ISSUE,
    S_WSTART,
    S_WDONE,
    S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] base_q, base_d;
  logic        reg_space_q, reg_space_d;
  logic [1:0]  rd_pend_q, rd_pend_d;   // per half: a controller read is still owed
  logic [1:0]  wr_pend_q, wr_pend_d;   // per half: a controller write is still owed
  logic        half_q, half_d;
  logic        cur_rd_q, cur_rd_d;     // transaction in flight is a read
  logic [31:0] rbuf_q, rbuf_d;         // read data per half, source of RMW merges
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [31:0] hb_adr_q, hb_adr_d;
  logic [15:0] hb_dat_q, hb_dat_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic        wrq_c, rrq_c, ack_c, wb_err_c;
  logic        nh_c, has_c, stop_c, err_now_c;
  logic [15:0] wd_c, rb_c;
  logic [1:0]  s_c;

  logic unused_c;
  assign unused_c = ^bus.wb_adr_i[1:0];

  // Next-state, datapath updates and request/acknowledge decode
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    sel_d       = sel_q;
    wdat_d      = wdat_q;
    base_d      = base_q;
    reg_space_d = reg_space_q;
    rd_pend_d   = rd_pend_q;
    wr_pend_d   = wr_pend_q;
    half_d      = half_q;
    cur_rd_d    = cur_rd_q;
    rbuf_d      = rbuf_q;
    wb_dat_d    = wb_dat_q;
    hb_adr_d    = hb_adr_q;
    hb_dat_d    = hb_dat_q;
    err_d       = err_q;
    abort_d     = abort_q;
    tmo_d       = tmo_q;
    wrq_c       = 1'b0;
    rrq_c       = 1'b0;
    ack_c       = 1'b0;
    wb_err_c    = 1'b0;
    nh_c        = half_q;
    has_c       = 1'b0;
    stop_c      = 1'b0;
    err_now_c   = err_q;
    wd_c        = '0;
    rb_c        = '0;
    s_c         = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          we_d        = bus.wb_we_i;
          sel_d       = bus.wb_sel_i;
          wdat_d      = bus.wb_dat_i;
          base_d      = {2'b00, bus.wb_adr_i[30:2], 1'b0};
          reg_space_d = bus.wb_adr_i[31];
          half_d      = 1'b0;
          err_d       = 1'b0;
          abort_d     = 1'b0;
          for (int h = 0; h < 2; h++) begin
            if (bus.wb_we_i) begin
              // full pair writes directly; a single byte needs read-modify-write
              wr_pend_d[h] = |bus.wb_sel_i[2*h +: 2];
              rd_pend_d[h] = ^bus.wb_sel_i[2*h +: 2];
            end else begin
              rd_pend_d[h] = |bus.wb_sel_i[2*h +: 2];
              wr_pend_d[h] = 1'b0;
              if (bus.wb_sel_i[2*h +: 2] == 2'b00) begin
                wb_dat_d[16*h +: 16] = READ_SKIP_VAL;
              end
            end
          end
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (!bus.wb_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          if (rd_pend_q[half_q] || wr_pend_q[half_q]) begin
            nh_c  = half_q;
            has_c = 1'b1;
          end else if (!half_q && (rd_pend_q[1] || wr_pend_q[1])) begin
            nh_c  = 1'b1;
            has_c = 1'b1;
          end
          if (has_c) begin
            wd_c     = wdat_q[{nh_c, 4'b0000} +: 16];
            rb_c     = rbuf_q[{nh_c, 4'b0000} +: 16];
            s_c      = sel_q[{nh_c, 1'b0} +: 2];
            half_d   = nh_c;
            cur_rd_d = rd_pend_q[nh_c];
            hb_adr_d = {base_q[31:1], nh_c};
            // selected bytes come from the bus, the rest from the preceding read
            hb_dat_d = {s_c[1] ? wd_c[15:8] : rb_c[15:8],
                        s_c[0] ? wd_c[7:0]  : rb_c[7:0]};
            state_d  = S_ISSUE;
          end else begin
            state_d = S_ACK;
          end
        end
      end

      S_ISSUE: begin
        if (!bus.wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (!bus.hb_busy_i) begin
          rrq_c   = cur_rd_q;
          wrq_c   = !cur_rd_q;
          tmo_d   = '0;
          state_d = S_WSTART;
        end
      end

      S_WSTART: begin
        stop_c  = abort_q || !bus.wb_cyc_i;
        abort_d = stop_c;
        if (bus.hb_busy_i) begin
          state_d = S_WDONE;
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          if (stop_c) begin
            err_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ACK;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_WDONE: begin
        stop_c  = abort_q || !bus.wb_cyc_i;
        abort_d = stop_c;
        if (!bus.hb_busy_i) begin
          if (cur_rd_q) begin
            rd_pend_d[half_q]              = 1'b0;
            rbuf_d[{half_q, 4'b0000} +: 16] = bus.hb_dat_i;
            if (!we_q) begin
              wb_dat_d[{half_q, 4'b0000} +: 16] = bus.hb_dat_i;
            end
          end else begin
            wr_pend_d[half_q] = 1'b0;
          end
          err_now_c = err_q || bus.hb_error_i;
          err_d     = err_now_c;
          if (stop_c) begin
            err_d   = 1'b0;
            state_d = S_IDLE;
          end else if (err_now_c || !(|(rd_pend_d | wr_pend_d))) begin
            // an error drops whatever is still owed, including an RMW write
            state_d = S_ACK;
          end else begin
            state_d = S_NEXT;
          end
        end
      end

      S_ACK: begin
        ack_c    = !err_q;
        wb_err_c = err_q;
        err_d    = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      sel_q       <= '0;
      wdat_q      <= '0;
      base_q      <= '0;
      reg_space_q <= 1'b0;
      rd_pend_q   <= '0;
      wr_pend_q   <= '0;
      half_q      <= 1'b0;
      cur_rd_q    <= 1'b0;
      rbuf_q      <= '0;
      wb_dat_q    <= '0;
      hb_adr_q    <= '0;
      hb_dat_q    <= '0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      wdat_q      <= wdat_d;
      base_q      <= base_d;
      reg_space_q <= reg_space_d;
      rd_pend_q   <= rd_pend_d;
      wr_pend_q   <= wr_pend_d;
      half_q      <= half_d;
      cur_rd_q    <= cur_rd_d;
      rbuf_q      <= rbuf_d;
      wb_dat_q    <= wb_dat_d;
      hb_adr_q    <= hb_adr_d;
      hb_dat_q    <= hb_dat_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.wb_dat_o       = wb_dat_q;
  assign bus.wb_ack_o       = ack_c;
  assign bus.wb_err_o       = wb_err_c;
  assign bus.hb_adr_o       = hb_adr_q;
  assign bus.hb_dat_o       = hb_dat_q;
  assign bus.hb_wrq_o       = wrq_c;
  assign bus.hb_rrq_o       = rrq_c;
  assign bus.hb_reg_space_o = reg_space_q;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// tb/tb_hyperbus_wb_bridge.sv - directed vectors for hyperbus_wb_bridge
module tb_hyperbus_wb_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyperbus_wb_bridge_if bus ();

  hyperbus_wb_bridge #(.START_TIMEOUT(8), .READ_SKIP_VAL(16'hC3C3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // controller model
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [15:0] d;
    logic        rs;
  } tx_t;

  tx_t         txlog[$];
  logic [15:0] rq[$];
  int          m_blen = 1;
  logic        m_nobusy = 1'b0;
  logic        m_errinj = 1'b0;
  int          m_done = 0;
  int          m_cnt = 0;
  logic        m_rd_pend = 1'b0;
  logic        pulse_seen = 1'b0;
  logic        pulse_rd = 1'b0;
  logic        m_busy, m_err;
  logic [15:0] m_dat;

  assign bus.hb_busy_i  = m_busy;
  assign bus.hb_error_i = m_err;
  assign bus.hb_dat_i   = m_dat;

  always @(negedge clk) begin
    pulse_seen = !rst && (bus.hb_wrq_o || bus.hb_rrq_o);
    pulse_rd   = bus.hb_rrq_o;
    if (pulse_seen) txlog.push_back('{bus.hb_wrq_o, bus.hb_adr_o, bus.hb_dat_o, bus.hb_reg_space_o});
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_err  <= 1'b0;
      m_dat  <= 16'h0;
      m_cnt  = 0;
    end else begin
      m_err <= 1'b0;
      if (pulse_seen && !m_nobusy) begin
        m_busy    <= 1'b1;
        m_cnt     = m_blen;
        m_rd_pend = pulse_rd;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          m_err  <= m_errinj && (m_done == 0);
          if (m_rd_pend && rq.size() > 0) m_dat <= rq.pop_front();
          m_done++;
        end
      end
    end
  end

  typedef struct {
    logic            we;
    logic [31:0]     adr;
    logic [3:0]      sel;
    logic [31:0]     dat;
    int              blen;
    logic            nobusy;
    logic            errinj;
    logic [15:0]     rd0, rd1;
    int              ntx;
    logic [2:0]      tw;
    logic [2:0][31:0] ta;
    logic [2:0][15:0] td;
    logic            xerr;
    logic            xrs;
    int              xlat;
    logic [31:0]     xrdat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat, input int blen, input logic [15:0] rd0,
                              input logic [15:0] rd1, input logic xerr, input logic xrs,
                              input int xlat, input logic [31:0] xrdat);
    vec_t v;
    v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.blen = blen;
    v.nobusy = 1'b0; v.errinj = 1'b0; v.rd0 = rd0; v.rd1 = rd1;
    v.ntx = 0; v.tw = '0; v.ta = '0; v.td = '0;
    v.xerr = xerr; v.xrs = xrs; v.xlat = xlat; v.xrdat = xrdat;
    return v;
  endfunction

  function automatic vec_t tx(input vec_t vi, input logic w, input logic [31:0] a, input logic [15:0] d);
    vec_t v = vi;
    v.tw[v.ntx] = w;
    v.ta[v.ntx] = a;
    v.td[v.ntx] = d;
    v.ntx++;
    return v;
  endfunction

  task automatic start_access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
  endtask

  task automatic end_access();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int          lat;
    logic        ga, ge;
    logic [31:0] rdat;
    string       nm;
    txlog.delete();
    rq.delete();
    rq.push_back(v.rd0);
    rq.push_back(v.rd1);
    m_blen = v.blen; m_nobusy = v.nobusy; m_errinj = v.errinj; m_done = 0;
    start_access(v.we, v.adr, v.sel, v.dat);
    lat = 0; ga = 1'b0; ge = 1'b0; rdat = '0;
    @(posedge clk);
    while (lat < 200 && !ga && !ge) begin
      @(negedge clk);
      lat++;
      ga   = bus.wb_ack_o;
      ge   = bus.wb_err_o;
      rdat = bus.wb_dat_o;
    end
    end_access();
    nm = $sformatf("v%0d", idx);
    check({nm, " ack"}, 32'(ga), 32'(!v.xerr));
    check({nm, " err"}, 32'(ge), 32'(v.xerr));
    check({nm, " latency"}, 32'(lat), 32'(v.xlat));
    check({nm, " ntx"}, 32'(txlog.size()), 32'(v.ntx));
    for (int k = 0; k < v.ntx && k < txlog.size(); k++) begin
      check($sformatf("%s tx%0d kind", nm, k), 32'(txlog[k].w), 32'(v.tw[k]));
      check($sformatf("%s tx%0d adr", nm, k), txlog[k].a, v.ta[k]);
      check($sformatf("%s tx%0d regsp", nm, k), 32'(txlog[k].rs), 32'(v.xrs));
      if (v.tw[k]) check($sformatf("%s tx%0d dat", nm, k), 32'(txlog[k].d), 32'(v.td[k]));
    end
    if (!v.we && !v.xerr) check({nm, " rdata"}, rdat, v.xrdat);
    @(negedge clk);
    check({nm, " ack width"}, 32'(bus.wb_ack_o | bus.wb_err_o), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " wb_dat_o"}, bus.wb_dat_o, 32'h0);
    check({tag, " ack/err"}, 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
    check({tag, " hb_adr_o"}, bus.hb_adr_o, 32'h0);
    check({tag, " hb_dat_o"}, 32'(bus.hb_dat_o), 32'h0);
    check({tag, " wrq/rrq/rs"}, 32'({bus.hb_wrq_o, bus.hb_rrq_o, bus.hb_reg_space_o}), 32'h0);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    rst = 1'b1;
    end_access();
    bus.wb_we_i = 1'b0; bus.wb_sel_i = '0; bus.wb_adr_i = '0; bus.wb_dat_i = '0;

    // full write, two halves
    v = mk(1, 32'h10, 4'hF, 32'hDEADBEEF, 5, 0, 0, 0, 0, 17, 0);
    v = tx(v, 1, 32'h8, 16'hBEEF); v = tx(v, 1, 32'h9, 16'hDEAD); vecs.push_back(v);
    // register-space full read
    v = mk(0, 32'h80000004, 4'hF, 0, 3, 16'h1234, 16'h5678, 0, 1, 13, 32'h56781234);
    v = tx(v, 0, 32'h2, 0); v = tx(v, 0, 32'h3, 0); vecs.push_back(v);
    // byte write low half -> RMW
    v = mk(1, 32'h20, 4'b0010, 32'h0000AB00, 2, 16'h1122, 0, 0, 0, 11, 0);
    v = tx(v, 0, 32'h10, 0); v = tx(v, 1, 32'h10, 16'hAB22); vecs.push_back(v);
    // low-half read, high half skipped
    v = mk(0, 32'h40, 4'b0011, 0, 2, 16'h9999, 0, 0, 0, 6, 32'hC3C39999);
    v = tx(v, 0, 32'h20, 0); vecs.push_back(v);
    // all-zero select write
    v = mk(1, 32'h44, 4'h0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 2, 0); vecs.push_back(v);
    // controller error on low-half write
    v = mk(1, 32'h10, 4'hF, 32'h11112222, 3, 0, 0, 1, 0, 7, 0);
    v.errinj = 1'b1; v = tx(v, 1, 32'h8, 16'h2222); vecs.push_back(v);
    // high-half-only read
    v = mk(0, 32'h0, 4'b1100, 0, 1, 16'hBEEF, 0, 0, 0, 5, 32'hBEEFC3C3);
    v = tx(v, 0, 32'h1, 0); vecs.push_back(v);
    // byte write high half -> RMW
    v = mk(1, 32'h100, 4'b1000, 32'h77000000, 1, 16'h1234, 0, 0, 0, 9, 0);
    v = tx(v, 0, 32'h81, 0); v = tx(v, 1, 32'h81, 16'h7734); vecs.push_back(v);
    // busy never rises -> timeout error
    v = mk(0, 32'h8, 4'b0011, 0, 1, 0, 0, 1, 0, 11, 0);
    v.nobusy = 1'b1; v = tx(v, 0, 32'h4, 0); vecs.push_back(v);
    // failed RMW read: no write follows
    v = mk(1, 32'h8000000C, 4'b0100, 32'h00330000, 2, 16'hAAAA, 0, 1, 1, 6, 0);
    v.errinj = 1'b1; v = tx(v, 0, 32'h7, 0); vecs.push_back(v);
    // register-space low-byte RMW
    v = mk(1, 32'h80000000, 4'b0001, 32'h000000EE, 1, 16'h5566, 0, 0, 1, 9, 0);
    v = tx(v, 0, 32'h0, 0); v = tx(v, 1, 32'h0, 16'h55EE); vecs.push_back(v);

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // abort during WDONE of the low half
    txlog.delete(); rq.delete(); m_blen = 4; m_nobusy = 1'b0; m_errinj = 1'b0; m_done = 0;
    start_access(1'b1, 32'h10, 4'hF, 32'h12345678);
    @(posedge clk);
    n = 0;
    while (!bus.hb_wrq_o && n < 20) begin @(negedge clk); n++; end
    check("abort pulse seen", 32'(bus.hb_wrq_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    end_access();
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.wb_ack_o || bus.wb_err_o || bus.hb_rrq_o) seen = 1'b1;
    end
    check("abort no ack/err", 32'(seen), 32'd0);
    check("abort ntx", 32'(txlog.size()), 32'd1);
    if (txlog.size() > 0) check("abort tx adr", txlog[0].a, 32'h8);
    apply_vec(vecs[1], 100);

    // reset during WSTART
    txlog.delete(); rq.delete(); m_blen = 4; m_done = 0;
    start_access(1'b0, 32'h80000010, 4'hF, 32'h0);
    @(posedge clk);
    n = 0;
    while (!bus.hb_rrq_o && n < 20) begin @(negedge clk); n++; end
    check("pre-reset rrq", 32'(bus.hb_rrq_o), 32'd1);
    check("pre-reset regsp", 32'(bus.hb_reg_space_o), 32'd1);
    check("pre-reset adr", bus.hb_adr_o, 32'h8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    end_access();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    apply_vec(vecs[0], 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
